// File: rtl/memory_game_sm.sv
// Memory game controller: flashes an LFSR-derived 4x4 target pattern, then lets the
// player move a cursor and pick cells until every target is found or a miss occurs.
module memory_game_sm #(
  parameter int FLASH_CYCLES = 100000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       btn_center,
  output logic [1:0] X,
  output logic [1:0] Y,
  output logic [3:0] A0,
  output logic [3:0] A1,
  output logic [3:0] A2,
  output logic [3:0] A3,
  output logic [3:0] B0,
  output logic [3:0] B1,
  output logic [3:0] B2,
  output logic [3:0] B3,
  output logic       Qi,
  output logic       Qfo,
  output logic       Qp,
  output logic       Qg,
  output logic       Ql
);

  localparam int CW = $clog2(FLASH_CYCLES + 1);
  localparam logic [CW-1:0] FLASH_LAST = CW'(FLASH_CYCLES - 1);

  // One-hot encoding so each status flag is a state register bit.
  typedef enum logic [4:0] {
    S_INIT  = 5'b00001,
    S_FLASH = 5'b00010,
    S_PLAY  = 5'b00100,
    S_WIN   = 5'b01000,
    S_LOSE  = 5'b10000
  } state_t;

  state_t        r_state, w_state_nxt;
  logic [15:0]   r_lfsr, w_lfsr_nxt;
  logic [15:0]   r_a, w_a_nxt;
  logic [15:0]   r_b, w_b_nxt;
  logic [1:0]    r_x, w_x_nxt;
  logic [1:0]    r_y, w_y_nxt;
  logic [4:0]    r_hit, w_hit_nxt;
  logic [4:0]    r_tgt, w_tgt_nxt;
  logic [CW-1:0] r_cnt, w_cnt_nxt;
  logic [15:0]   w_pattern;
  logic [3:0]    w_idx;

  function automatic logic [4:0] popcount16(input logic [15:0] v);
    logic [4:0] s;
    s = '0;
    for (int i = 0; i < 16; i++) s = s + {4'b0, v[i]};
    return s;
  endfunction

  // An all-zero pattern would be unwinnable, so it is forced to a single target.
  assign w_pattern = (r_lfsr == 16'h0000) ? 16'h0001 : r_lfsr;
  assign w_idx     = {r_x, r_y};

  always_comb begin
    w_state_nxt = r_state;
    w_lfsr_nxt  = {r_lfsr[14:0], r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};
    w_a_nxt     = r_a;
    w_b_nxt     = r_b;
    w_x_nxt     = r_x;
    w_y_nxt     = r_y;
    w_hit_nxt   = r_hit;
    w_tgt_nxt   = r_tgt;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      S_INIT: begin
        if (start) begin
          w_state_nxt = S_FLASH;
          w_a_nxt     = w_pattern;
          w_tgt_nxt   = popcount16(w_pattern);
          w_b_nxt     = '0;
          w_hit_nxt   = '0;
          w_x_nxt     = '0;
          w_y_nxt     = '0;
          w_cnt_nxt   = '0;
        end
      end
      S_FLASH: begin
        w_cnt_nxt = r_cnt + 1'b1;
        if (r_cnt == FLASH_LAST) w_state_nxt = S_PLAY;
      end
      S_PLAY: begin
        if (btn_center) begin
          if (!r_b[w_idx]) begin
            w_b_nxt[w_idx] = 1'b1;
            if (!r_a[w_idx]) begin
              w_state_nxt = S_LOSE;
            end else begin
              w_hit_nxt = r_hit + 5'd1;
              if (r_hit + 5'd1 == r_tgt) w_state_nxt = S_WIN;
            end
          end
        end else if (btn_up) begin
          w_x_nxt = r_x - 2'd1;
        end else if (btn_down) begin
          w_x_nxt = r_x + 2'd1;
        end else if (btn_left) begin
          w_y_nxt = r_y - 2'd1;
        end else if (btn_right) begin
          w_y_nxt = r_y + 2'd1;
        end
      end
      S_WIN, S_LOSE: begin
        if (start) w_state_nxt = S_INIT;
      end
      default: w_state_nxt = S_INIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_INIT;
      r_lfsr  <= 16'hACE1;
      r_a     <= '0;
      r_b     <= '0;
      r_x     <= '0;
      r_y     <= '0;
      r_hit   <= '0;
      r_tgt   <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_lfsr  <= w_lfsr_nxt;
      r_a     <= w_a_nxt;
      r_b     <= w_b_nxt;
      r_x     <= w_x_nxt;
      r_y     <= w_y_nxt;
      r_hit   <= w_hit_nxt;
      r_tgt   <= w_tgt_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  assign X   = r_x;
  assign Y   = r_y;
  assign A0  = r_a[3:0];
  assign A1  = r_a[7:4];
  assign A2  = r_a[11:8];
  assign A3  = r_a[15:12];
  assign B0  = r_b[3:0];
  assign B1  = r_b[7:4];
  assign B2  = r_b[11:8];
  assign B3  = r_b[15:12];
  assign Qi  = r_state[0];
  assign Qfo = r_state[1];
  assign Qp  = r_state[2];
  assign Qg  = r_state[3];
  assign Ql  = r_state[4];

endmodule

// File: tb/tb_memory_game_sm.sv
// Directed bench for memory_game_sm with FLASH_CYCLES=4 and a reference LFSR model.
module tb_memory_game_sm;

  localparam logic [4:0] F_INIT  = 5'b10000;  // {Qi,Qfo,Qp,Qg,Ql}
  localparam logic [4:0] F_FLASH = 5'b01000;
  localparam logic [4:0] F_PLAY  = 5'b00100;
  localparam logic [4:0] F_WIN   = 5'b00010;
  localparam logic [4:0] F_LOSE  = 5'b00001;
  localparam logic [4:0] K_CEN   = 5'b10000;  // {center,up,down,left,right}
  localparam logic [4:0] K_UP    = 5'b01000;
  localparam logic [4:0] K_DN    = 5'b00100;
  localparam logic [4:0] K_LT    = 5'b00010;
  localparam logic [4:0] K_RT    = 5'b00001;

  logic clk = 1'b0;
  logic rst, start, btn_up, btn_down, btn_left, btn_right, btn_center;
  logic [1:0] X, Y;
  logic [3:0] A0, A1, A2, A3, B0, B1, B2, B3;
  logic Qi, Qfo, Qp, Qg, Ql;

  int checks = 0;
  int errors = 0;
  int tb_x, tb_y, zidx, tcnt, found;
  int tgt [3];
  logic [15:0] m_lfsr, exp_a, exp_b;

  memory_game_sm #(.FLASH_CYCLES(4)) dut (
    .clk(clk), .rst(rst), .start(start),
    .btn_up(btn_up), .btn_down(btn_down), .btn_left(btn_left),
    .btn_right(btn_right), .btn_center(btn_center),
    .X(X), .Y(Y), .A0(A0), .A1(A1), .A2(A2), .A3(A3),
    .B0(B0), .B1(B1), .B2(B2), .B3(B3),
    .Qi(Qi), .Qfo(Qfo), .Qp(Qp), .Qg(Qg), .Ql(Ql)
  );

  always #5 clk = ~clk;

  // Reference LFSR: x^16+x^14+x^13+x^11+1, advancing on every edge.
  always @(posedge clk) begin
    if (rst) m_lfsr <= 16'hACE1;
    else     m_lfsr <= {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
  end

  function automatic int pc(input logic [15:0] v);
    int s = 0;
    for (int i = 0; i < 16; i++) s += int'(v[i]);
    return s;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic press(input logic [4:0] k);
    {btn_center, btn_up, btn_down, btn_left, btn_right} = k;
    cyc();
    {btn_center, btn_up, btn_down, btn_left, btn_right} = 5'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    cyc();
    start = 1'b0;
  endtask

  task automatic goto_cell(input int idx);
    repeat (((idx >> 2) - tb_x) & 3) press(K_DN);
    repeat (((idx & 3) - tb_y) & 3) press(K_RT);
    tb_x = idx >> 2;
    tb_y = idx & 3;
  endtask

  function automatic logic [4:0] flags();
    return {Qi, Qfo, Qp, Qg, Ql};
  endfunction

  function automatic logic [15:0] amask();
    return {A3, A2, A1, A0};
  endfunction

  function automatic logic [15:0] bmask();
    return {B3, B2, B1, B0};
  endfunction

  initial begin
    rst = 1'b1; start = 1'b0;
    {btn_center, btn_up, btn_down, btn_left, btn_right} = 5'b0;
    cyc(); cyc();
    chk("rst_flags", flags(), F_INIT);
    chk("rst_X", X, 0);
    chk("rst_Y", Y, 0);
    chk("rst_A", amask(), 16'h0);
    chk("rst_B", bmask(), 16'h0);
    rst = 1'b0;
    cyc();
    chk("idle_flags", flags(), F_INIT);
    press(K_CEN);
    chk("init_btn_ignored", {flags(), bmask()}, {F_INIT, 16'h0});
    cyc(); cyc();

    // Round 1: cursor wrap tests, then a miss.
    exp_a = (m_lfsr == 16'h0) ? 16'h0001 : m_lfsr;
    pulse_start();
    chk("flash_A", amask(), exp_a);
    chk("flash_B", bmask(), 16'h0);
    for (int i = 0; i < 4; i++) begin
      chk("flash_on", flags(), F_FLASH);
      if (i == 1) press(K_CEN | K_RT); else cyc();
    end
    chk("play_flags", flags(), F_PLAY);
    chk("play_B", bmask(), 16'h0);
    chk("play_XY", {X, Y}, 4'h0);
    press(K_RT); press(K_RT);
    chk("at_0_2", {X, Y}, {2'd0, 2'd2});
    press(K_UP);
    chk("up_wrap", X, 3);
    press(K_RT);
    chk("right_1", Y, 3);
    press(K_RT);
    chk("right_wrap", Y, 0);
    press(K_UP | K_LT);
    chk("up_left_prio", {X, Y}, {2'd2, 2'd0});
    press(K_DN); press(K_DN);
    chk("down_wrap", X, 0);
    press(K_LT);
    chk("left_wrap", Y, 3);
    press(K_RT);
    pulse_start();
    chk("play_start_ignored", {flags(), X, Y}, {F_PLAY, 4'h0});
    tb_x = 0; tb_y = 0;
    chk("has_zero_cell", (exp_a != 16'hFFFF), 1);
    zidx = -1;
    for (int i = 15; i >= 0; i--) if (!exp_a[i]) zidx = i;
    if (zidx < 0) zidx = 0;
    goto_cell(zidx);
    press(K_CEN);
    exp_b = 16'h0001 << zidx;
    chk("lose_flags", flags(), F_LOSE);
    chk("lose_B", bmask(), exp_b);
    press(K_CEN); press(K_DN); press(K_RT);
    chk("lose_hold", {flags(), X, Y, bmask(), amask()},
        {F_LOSE, 2'(zidx >> 2), 2'(zidx & 3), exp_b, exp_a});
    pulse_start();
    chk("lose_to_init", {flags(), amask(), bmask()}, {F_INIT, exp_a, exp_b});

    // Round 2: wait for an LFSR value with exactly three targets.
    found = 0;
    for (int k = 0; k < 5000 && found == 0; k++) begin
      if (pc(m_lfsr) == 3) found = 1;
      else cyc();
    end
    chk("lfsr3_found", found, 1);
    exp_a = m_lfsr;
    pulse_start();
    chk("r2_A", amask(), exp_a);
    repeat (4) cyc();
    chk("r2_play", flags(), F_PLAY);
    tb_x = 0; tb_y = 0; tcnt = 0; exp_b = 16'h0;
    for (int i = 0; i < 16; i++) if (exp_a[i] && tcnt < 3) begin tgt[tcnt] = i; tcnt++; end
    goto_cell(tgt[0]); press(K_CEN); exp_b[tgt[0]] = 1'b1;
    chk("hit1", {flags(), bmask()}, {F_PLAY, exp_b});
    goto_cell(tgt[1]); press(K_CEN); exp_b[tgt[1]] = 1'b1;
    chk("hit2", {flags(), bmask()}, {F_PLAY, exp_b});
    goto_cell(tgt[0]); press(K_CEN);
    chk("reselect", {flags(), bmask()}, {F_PLAY, exp_b});
    goto_cell(tgt[2]); press(K_CEN); exp_b[tgt[2]] = 1'b1;
    chk("win_flags", flags(), F_WIN);
    chk("win_B_eq_A", bmask(), exp_a);
    press(K_DN);
    chk("win_hold", {flags(), X, Y}, {F_WIN, 2'(tgt[2] >> 2), 2'(tgt[2] & 3)});
    pulse_start();
    chk("win_to_init", {flags(), amask(), bmask()}, {F_INIT, exp_a, exp_a});

    // Reset in the second FLASH cycle, together with start.
    pulse_start();
    chk("r3_flash", flags(), F_FLASH);
    cyc();
    rst = 1'b1; start = 1'b1;
    cyc();
    rst = 1'b0; start = 1'b0;
    chk("midflash_rst", {flags(), X, Y, amask(), bmask()}, {F_INIT, 4'h0, 16'h0, 16'h0});
    for (int i = 0; i < 6; i++) begin
      cyc();
      chk("no_play_after_rst", flags(), F_INIT);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
